exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_BOOT, default 32'hBFC00380, meaning exception vector when Status.BEV=1.
REQ-002 The block SHALL have parameter VEC_NORM, default 32'h80000180, meaning exception vector when Status.BEV=0.
REQ-003 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_stall_i  in  1  MEM stage stalled this cycle
- mem_pc_i  in  32  PC of MEM instruction
- mem_inslot_i  in  1  MEM instruction is in a delay slot
- mem_maddr_i  in  32  data access address
- exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sysc_i, exc_bp_i, exc_eret_i, exc_adel_ld_i, exc_ades_i  in  1 each  per-cause flags carried to MEM
- intr_i  in  1  CP0 exc_intr
- status_i  in  32  CP0 Status
- epc_i  in  32  CP0 EPC
- exc_flag_o  out  1  to CP0
- exc_type_o  out  `ExcT  to CP0
- exc_pc_o  out  32  to CP0
- exc_inslot_o  out  1  to CP0
- exc_baddr_o  out  32  to CP0
- flush_o  out  1  flush IF..MEM
- redirect_valid_o  out  1  redirect request to IF
- redirect_pc_o  out  32  target PC
- redirect_ready_i  in  1  IF accepted redirect

Function
REQ-005 FSM states SHALL be IDLE and REDIR; reset state IDLE.
REQ-006 Commit SHALL occur in a cycle where state=IDLE, mem_valid_i=1, mem_stall_i=0, and (intr_i or any cause flag)=1.
REQ-007 Cause priority SHALL be: intr > AdEL1 (fetch) > RI > Ov > SysC > Bp > ERET > AdEL2 (load) > AdES; exactly one type is reported.
REQ-008 In the commit cycle, exc_flag_o=1, exc_type_o=winning type, exc_pc_o=mem_pc_i, exc_inslot_o=mem_inslot_i, and flush_o=1; these outputs SHALL be combinational and otherwise 0.
REQ-009 exc_baddr_o SHALL be mem_pc_i for AdEL1, mem_maddr_i for AdEL2/AdES, and 0 otherwise.
REQ-010 At the commit edge, the block SHALL register redirect_pc_o: epc_i for ERET; otherwise VEC_BOOT if status_i[22]=1, else VEC_NORM. The state SHALL become REDIR.
REQ-011 In REDIR, redirect_valid_o=1 and redirect_pc_o SHALL be held stable until redirect_ready_i=1; on ready the state SHALL return to IDLE at that edge.
REQ-012 In REDIR, all cause flags and intr_i SHALL be ignored (no exc_flag_o, no flush_o).
REQ-013 If mem_stall_i=1 with flags pending, there SHALL be no commit; the commit SHALL occur in the first unstalled cycle with the then-current inputs.
REQ-014 intr_i with mem_valid_i=0 SHALL NOT commit; the interrupt waits for the next valid instruction.
REQ-015 Redirect latency SHALL be: commit at cycle N, redirect_valid_o high from N+1.
REQ-016 A new commit in the same cycle redirect_ready_i is accepted SHALL be impossible (state is REDIR); the earliest next commit is the cycle after return to IDLE.

Reset
REQ-017 On rst_n=0 the block SHALL asynchronously set state=IDLE, redirect_valid_o=0, and redirect_pc_o=0; all combinational outputs SHALL be 0 while inputs are idle.
REQ-018 Reset asserted in REDIR SHALL drop redirect_valid_o immediately, and no redirect SHALL follow.

Verification
REQ-019 Bench: ov=1, pc=0x80001000, BEV=1, unstalled -> same cycle flag=1, type=Ov, flush=1; next cycle redirect_valid=1, pc=0xBFC00380.
REQ-020 Bench: ri=1 and ades=1 together, inslot=1, pc=0x80002004, BEV=0 -> type=RI, inslot_o=1, baddr=0, redirect 0x80000180.
REQ-021 Bench: ades=1, maddr=0x80003002, stall=1 for 3 cycles -> no flag during the stall; in the 4th cycle flag=1, baddr=0x80003002.
REQ-022 Bench: eret=1, epc_i=0x80004010 -> type=ERET, redirect_pc=0x80004010; ready held low 5 cycles -> valid and pc stable, with a concurrent sysc ignored.
REQ-023 Bench: intr_i=1 with mem_valid=0 for 2 cycles, then valid, pc=0x80005000 -> commit type=Intr with exc_pc=0x80005000.
REQ-024 Bench: rst_n low while in REDIR -> redirect_valid_o=0 immediately; after release, state is IDLE and there is no redirect.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception commit controller: picks the winning cause at MEM, informs CP0,
// flushes the pipe and hands a redirect PC to IF over a valid/ready handshake.
package exc_pkg;
  typedef logic [3:0] exc_t;
  localparam exc_t EXC_NONE    = 4'd0;
  localparam exc_t EXC_INTR    = 4'd1;
  localparam exc_t EXC_ADEL_IF = 4'd2;
  localparam exc_t EXC_RI      = 4'd3;
  localparam exc_t EXC_OV      = 4'd4;
  localparam exc_t EXC_SYSC    = 4'd5;
  localparam exc_t EXC_BP      = 4'd6;
  localparam exc_t EXC_ERET    = 4'd7;
  localparam exc_t EXC_ADEL_LD = 4'd8;
  localparam exc_t EXC_ADES    = 4'd9;
endpackage

module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BOOT = 32'hBFC00380,
  parameter logic [31:0] VEC_NORM = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_inslot_i,
  input  logic [31:0] mem_maddr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_sysc_i,
  input  logic        exc_bp_i,
  input  logic        exc_eret_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic        intr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] epc_i,
  output logic        exc_flag_o,
  output exc_t        exc_type_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_inslot_o,
  output logic [31:0] exc_baddr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t state, state_nxt;
  exc_t   cause;
  logic   any_cause;
  logic   commit;

  assign any_cause = intr_i | exc_adel_if_i | exc_ri_i
                   | exc_ov_i | exc_sysc_i | exc_bp_i
                   | exc_eret_i | exc_adel_ld_i | exc_ades_i;

  assign commit = (state == IDLE) & mem_valid_i
                & ~mem_stall_i & any_cause;

  // Overlapping flags: first match in this chain wins.
  always_comb begin
    cause = EXC_NONE;
    if      (intr_i)        cause = EXC_INTR;
    else if (exc_adel_if_i) cause = EXC_ADEL_IF;
    else if (exc_ri_i)      cause = EXC_RI;
    else if (exc_ov_i)      cause = EXC_OV;
    else if (exc_sysc_i)    cause = EXC_SYSC;
    else if (exc_bp_i)      cause = EXC_BP;
    else if (exc_eret_i)    cause = EXC_ERET;
    else if (exc_adel_ld_i) cause = EXC_ADEL_LD;
    else if (exc_ades_i)    cause = EXC_ADES;
  end

  always_comb begin
    exc_flag_o   = 1'b0;
    exc_type_o   = EXC_NONE;
    exc_pc_o     = '0;
    exc_inslot_o = 1'b0;
    exc_baddr_o  = '0;
    flush_o      = 1'b0;
    if (commit) begin
      exc_flag_o   = 1'b1;
      exc_type_o   = cause;
      exc_pc_o     = mem_pc_i;
      exc_inslot_o = mem_inslot_i;
      flush_o      = 1'b1;
      if (cause == EXC_ADEL_IF)
        exc_baddr_o = mem_pc_i;
      else if (cause == EXC_ADEL_LD || cause == EXC_ADES)
        exc_baddr_o = mem_maddr_i;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (commit) state_nxt = REDIR;
      REDIR: if (redirect_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      redirect_pc_o <= '0;
    else if (commit)
      redirect_pc_o <= (cause == EXC_ERET) ? epc_i
                     : status_i[22] ? VEC_BOOT : VEC_NORM;
  end

  assign redirect_valid_o = (state == REDIR);

endmodule
